// File: rtl/adc_scan_sequencer.sv
// Round-robin ADC scan sequencer: issues one command per slot, captures the matching result, flags errors.
// Optional per-slot 4-sample averaging is enabled by defining ADC_SEQ_AVG_EN.
//
// state      | meaning
// S_IDLE     | stopped, waiting for enable
// S_SEND     | command presented, waiting for adc_command_ready
// S_WAIT_RSP | command accepted, waiting for the response or timeout
// S_ADVANCE  | one cycle to step to the next slot or close the scan
// S_GAP      | idle clocks between scans
module adc_scan_sequencer #(
  parameter int NUM_CH   = 2,
  parameter int CH_FIRST = 1,
  parameter int SCAN_GAP = 1000,
  parameter int TIMEOUT  = 255
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic                  enable,
  output logic                  adc_command_valid,
  output logic [4:0]            adc_command_channel,
  output logic                  adc_command_startofpacket,
  output logic                  adc_command_endofpacket,
  input  logic                  adc_command_ready,
  input  logic                  adc_response_valid,
  input  logic [4:0]            adc_response_channel,
  input  logic [11:0]           adc_response_data,
  output logic [12*NUM_CH-1:0]  samples,
  output logic [NUM_CH-1:0]     sample_valid,
  output logic                  scan_done,
  output logic                  err_mismatch,
  output logic                  err_timeout,
  input  logic                  err_clear
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TO_W  = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT);
  localparam logic [15:0]      GAP_LOAD = 16'(SCAN_GAP);
  localparam logic [4:0]       CH_BASE  = 5'(CH_FIRST);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_RSP,
    S_ADVANCE,
    S_GAP
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic [15:0]            gap_cnt_q, gap_cnt_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic [4:0]             cmd_ch_q, cmd_ch_d;
  logic [12*NUM_CH-1:0]   samples_q, samples_d;
  logic [NUM_CH-1:0]      sample_valid_q, sample_valid_d;
  logic                   scan_done_q, scan_done_d;
  logic                   err_mismatch_q, err_mismatch_d;
  logic                   err_timeout_q, err_timeout_d;

  logic [4:0]             slot_ch;
  logic                   set_mismatch;
  logic                   set_timeout;
  logic                   sample_wr;

`ifdef ADC_SEQ_AVG_EN
  logic [13:0]            acc_q [NUM_CH];
  logic [13:0]            acc_d [NUM_CH];
  logic [1:0]             avg_cnt_q [NUM_CH];
  logic [1:0]             avg_cnt_d [NUM_CH];
  logic [13:0]            acc_sum;
`endif

  assign slot_ch = CH_BASE + 5'(idx_q);

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    to_cnt_d       = to_cnt_q;
    gap_cnt_d      = gap_cnt_q;
    cmd_valid_d    = cmd_valid_q;
    cmd_ch_d       = cmd_ch_q;
    scan_done_d    = 1'b0;
    set_mismatch   = 1'b0;
    set_timeout    = 1'b0;
    sample_wr      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d     = S_SEND;
          idx_d       = '0;
          cmd_valid_d = 1'b1;
          cmd_ch_d    = CH_BASE;
        end
      end
      S_SEND: begin
        if (adc_command_ready) begin
          state_d     = S_WAIT_RSP;
          cmd_valid_d = 1'b0;
          to_cnt_d    = TO_LOAD;
        end
      end
      S_WAIT_RSP: begin
        if (adc_response_valid) begin
          if (adc_response_channel == slot_ch) sample_wr = 1'b1;
          else set_mismatch = 1'b1;
          state_d = S_ADVANCE;
        end else if (to_cnt_q <= TO_W'(1)) begin
          set_timeout = 1'b1;
          state_d     = S_ADVANCE;
        end else begin
          to_cnt_d = to_cnt_q - 1'b1;
        end
      end
      S_ADVANCE: begin
        if (idx_q != LAST_IDX) begin
          idx_d       = idx_q + 1'b1;
          state_d     = S_SEND;
          cmd_valid_d = 1'b1;
          cmd_ch_d    = slot_ch + 5'd1;
        end else begin
          scan_done_d = 1'b1;
          idx_d       = '0;
          if (SCAN_GAP == 0) begin
            // No gap: the run/stop decision is taken right here.
            state_d     = enable ? S_SEND : S_IDLE;
            cmd_valid_d = enable;
            cmd_ch_d    = enable ? CH_BASE : cmd_ch_q;
          end else begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_LOAD;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_q <= 16'd1) begin
          state_d     = enable ? S_SEND : S_IDLE;
          cmd_valid_d = enable;
          cmd_ch_d    = enable ? CH_BASE : cmd_ch_q;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Any response outside the wait window has no command to belong to.
    if (adc_response_valid && (state_q != S_WAIT_RSP)) set_mismatch = 1'b1;
  end

  always_comb begin
    samples_d      = samples_q;
    sample_valid_d = sample_valid_q;
    err_mismatch_d = (err_mismatch_q & ~err_clear) | set_mismatch;
    err_timeout_d  = (err_timeout_q & ~err_clear) | set_timeout;
`ifdef ADC_SEQ_AVG_EN
    acc_d     = acc_q;
    avg_cnt_d = avg_cnt_q;
    acc_sum   = acc_q[idx_q] + {2'b00, adc_response_data};
    if (sample_wr) begin
      if (avg_cnt_q[idx_q] == 2'd3) begin
        samples_d[int'(idx_q)*12 +: 12] = acc_sum[13:2];
        sample_valid_d[idx_q]           = 1'b1;
        acc_d[idx_q]                    = '0;
        avg_cnt_d[idx_q]                = '0;
      end else begin
        acc_d[idx_q]     = acc_sum;
        avg_cnt_d[idx_q] = avg_cnt_q[idx_q] + 2'd1;
      end
    end
`else
    if (sample_wr) begin
      samples_d[int'(idx_q)*12 +: 12] = adc_response_data;
      sample_valid_d[idx_q]           = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      to_cnt_q       <= '0;
      gap_cnt_q      <= '0;
      cmd_valid_q    <= 1'b0;
      cmd_ch_q       <= '0;
      samples_q      <= '0;
      sample_valid_q <= '0;
      scan_done_q    <= 1'b0;
      err_mismatch_q <= 1'b0;
      err_timeout_q  <= 1'b0;
`ifdef ADC_SEQ_AVG_EN
      for (int i = 0; i < NUM_CH; i++) begin
        acc_q[i]     <= '0;
        avg_cnt_q[i] <= '0;
      end
`endif
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      to_cnt_q       <= to_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      cmd_valid_q    <= cmd_valid_d;
      cmd_ch_q       <= cmd_ch_d;
      samples_q      <= samples_d;
      sample_valid_q <= sample_valid_d;
      scan_done_q    <= scan_done_d;
      err_mismatch_q <= err_mismatch_d;
      err_timeout_q  <= err_timeout_d;
`ifdef ADC_SEQ_AVG_EN
      acc_q     <= acc_d;
      avg_cnt_q <= avg_cnt_d;
`endif
    end
  end

  assign adc_command_valid         = cmd_valid_q;
  assign adc_command_channel       = cmd_ch_q;
  assign adc_command_startofpacket = cmd_valid_q;
  assign adc_command_endofpacket   = cmd_valid_q;
  assign samples                   = samples_q;
  assign sample_valid              = sample_valid_q;
  assign scan_done                 = scan_done_q;
  assign err_mismatch              = err_mismatch_q;
  assign err_timeout               = err_timeout_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: reactive ADC stand-in, event-scheduled reference model, per-cycle compare.
module tb_adc_scan_sequencer;
  localparam int NC = 2;
  localparam int CF = 1;
  localparam int SG = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_reset, enable, err_clear;
  logic              adc_command_valid, adc_command_sop, adc_command_eop;
  logic [4:0]        adc_command_channel;
  logic              adc_command_ready;
  logic              adc_response_valid;
  logic [4:0]        adc_response_channel;
  logic [11:0]       adc_response_data;
  logic [12*NC-1:0]  samples;
  logic [NC-1:0]     sample_valid;
  logic              scan_done, err_mismatch, err_timeout;

  adc_scan_sequencer #(.NUM_CH(NC), .CH_FIRST(CF), .SCAN_GAP(SG), .TIMEOUT(TO)) dut (
    .clk_clk(clk), .reset_reset(reset_reset), .enable(enable),
    .adc_command_valid(adc_command_valid), .adc_command_channel(adc_command_channel),
    .adc_command_startofpacket(adc_command_sop), .adc_command_endofpacket(adc_command_eop),
    .adc_command_ready(adc_command_ready), .adc_response_valid(adc_response_valid),
    .adc_response_channel(adc_response_channel), .adc_response_data(adc_response_data),
    .samples(samples), .sample_valid(sample_valid), .scan_done(scan_done),
    .err_mismatch(err_mismatch), .err_timeout(err_timeout), .err_clear(err_clear));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: scheduled events keyed on edge number
  longint      n = 0;
  bit          m_run = 0, m_valid = 0, m_wait = 0, m_done = 0, m_mm = 0, m_to = 0;
  int          m_slot = 0;
  logic [11:0] m_samp [NC];
  bit [NC-1:0] m_sv = '0;
  int          m_acc [NC];
  int          m_cnt [NC];
  longint      t_issue = -1, t_done = -1, t_decide = -1, t_deadline = -1;

  always @(posedge clk) begin
    bit run0, fin;
    n++;
    if (reset_reset) begin
      m_run = 0; m_valid = 0; m_wait = 0; m_done = 0; m_mm = 0; m_to = 0; m_slot = 0; m_sv = '0;
      for (int i = 0; i < NC; i++) begin m_samp[i] = '0; m_acc[i] = 0; m_cnt[i] = 0; end
      t_issue = -1; t_done = -1; t_decide = -1; t_deadline = -1;
    end else begin
      run0 = m_run; fin = 0; m_done = 0;
      if (err_clear) begin m_mm = 0; m_to = 0; end
      if (adc_response_valid) begin
        if (m_wait && int'(adc_response_channel) == CF + m_slot) begin
`ifdef ADC_SEQ_AVG_EN
          m_acc[m_slot] += int'(adc_response_data);
          m_cnt[m_slot]++;
          if (m_cnt[m_slot] == 4) begin
            m_samp[m_slot] = 12'(m_acc[m_slot] / 4);
            m_sv[m_slot] = 1'b1;
            m_acc[m_slot] = 0; m_cnt[m_slot] = 0;
          end
`else
          m_samp[m_slot] = adc_response_data;
          m_sv[m_slot] = 1'b1;
`endif
        end else m_mm = 1;
        if (m_wait) fin = 1;
      end else if (m_wait && n == t_deadline) begin
        m_to = 1; fin = 1;
      end
      if (m_valid && adc_command_ready) begin
        m_valid = 0; m_wait = 1; t_deadline = n + TO;
      end
      if (fin) begin
        m_wait = 0;
        if (m_slot < NC - 1) t_issue = n + 1;
        else begin t_done = n + 1; t_decide = n + 1 + SG; end
      end
      if (n == t_issue) begin m_slot++; m_valid = 1; end
      if (n == t_done) m_done = 1;
      if (n == t_decide) begin
        m_slot = 0;
        if (enable) m_valid = 1; else m_run = 0;
      end
      if (!run0 && enable) begin m_run = 1; m_valid = 1; m_slot = 0; end
    end
  end

  function automatic logic [12*NC-1:0] exp_samples();
    logic [12*NC-1:0] v;
    for (int i = 0; i < NC; i++) v[12*i +: 12] = m_samp[i];
    return v;
  endfunction

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("cmd_valid", adc_command_valid, m_valid);
      check("cmd_sop", adc_command_sop, m_valid);
      check("cmd_eop", adc_command_eop, m_valid);
      if (m_valid) check("cmd_channel", adc_command_channel, CF + m_slot);
      check("samples", samples, exp_samples());
      check("sample_valid", sample_valid, m_sv);
      check("scan_done", scan_done, m_done);
      check("err_mismatch", err_mismatch, m_mm);
      check("err_timeout", err_timeout, m_to);
    end
  end

  // ADC stand-in: ready policy and scheduled responses
  typedef struct { longint due; logic [4:0] ch; logic [11:0] data; } rsp_t;
  rsp_t   rq[$];
  longint ntick = 0;
  int     ready_mode = 0, hold_cnt = 0, rsp_mode = 0, data_mode = 0, avg_val = 100;
  bit     stray_en = 0;

  function automatic logic [11:0] gen_data(input logic [4:0] ch);
    logic [11:0] d;
    if (data_mode == 1) d = 12'($urandom);
    else if (data_mode == 2) begin
      if (ch == 5'(CF)) begin d = 12'(avg_val); avg_val++; end
      else d = 12'h055;
    end else d = (ch == 5'(CF)) ? 12'h123 : 12'hABC;
    return d;
  endfunction

  task automatic push(input longint due, input logic [4:0] ch, input logic [11:0] data);
    rsp_t r;
    r.due = due; r.ch = ch; r.data = data;
    rq.push_back(r);
  endtask

  always @(negedge clk) begin
    bit got;
    int r;
    ntick++;
    case (ready_mode)
      0: adc_command_ready = 1'b1;
      1: adc_command_ready = 1'($urandom_range(0, 1));
      default: begin
        if (hold_cnt > 0 && adc_command_valid) begin adc_command_ready = 1'b0; hold_cnt--; end
        else adc_command_ready = 1'b1;
      end
    endcase
    if (adc_command_valid && adc_command_ready && !reset_reset) begin
      case (rsp_mode)
        0: push(ntick + 3, adc_command_channel, gen_data(adc_command_channel));
        1: begin
          r = int'($urandom_range(0, 9));
          if (r == 1) push(ntick + longint'($urandom_range(1, 8)), adc_command_channel ^ 5'h4, 12'($urandom));
          else if (r != 0) push(ntick + longint'($urandom_range(1, 10)), adc_command_channel, gen_data(adc_command_channel));
        end
        2: begin push(ntick + 3, adc_command_channel ^ 5'h4, 12'h777); rsp_mode = 0; end
        default: begin push(ntick + TO + 2, adc_command_channel, 12'h666); rsp_mode = 0; end
      endcase
    end
    adc_response_valid = 1'b0; adc_response_channel = '0; adc_response_data = '0;
    got = 0;
    foreach (rq[i]) if (!got && rq[i].due == ntick) begin
      got = 1;
      adc_response_valid = 1'b1; adc_response_channel = rq[i].ch; adc_response_data = rq[i].data;
    end
    for (int i = rq.size() - 1; i >= 0; i--) if (rq[i].due <= ntick) rq.delete(i);
    if (!got && stray_en && $urandom_range(0, 39) == 0) begin
      adc_response_valid = 1'b1;
      adc_response_channel = 5'($urandom_range(0, 7));
      adc_response_data = 12'($urandom);
    end
  end

  task automatic wait_done(input int budget, output int elapsed);
    int k;
    elapsed = budget;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (scan_done) begin elapsed = k + 1; break; end
    end
    total++;
    if (k == budget) begin bad++; $display("FAIL wait_scan_done: no pulse within %0d cycles", budget); end
  endtask

  task automatic wait_valid(input int budget, input bit want);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (adc_command_valid == want) break;
    end
    total++;
    if (k == budget) begin bad++; $display("FAIL wait_valid: valid never became %0d", want); end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {adc_command_valid, adc_command_sop, adc_command_eop}, 3'b000);
    check({tag, "_channel"}, adc_command_channel, 5'd0);
    check({tag, "_samples"}, samples, '0);
    check({tag, "_flags"}, {sample_valid, scan_done, err_mismatch, err_timeout}, '0);
  endtask

  initial begin
    int e, vcount;
    reset_reset = 1'b1; enable = 1'b0; err_clear = 1'b0;
    adc_command_ready = 1'b1; adc_response_valid = 1'b0;
    adc_response_channel = '0; adc_response_data = '0;
    repeat (3) @(negedge clk);
    chk_en = 1;
    check_all_zero("reset");
    reset_reset = 1'b0;
    enable = 1'b1;

    // nominal scan: ready always high, responses 3 cycles after acceptance
    wait_done(200, e);
    check("first_scan_latency", e, 11);
`ifndef ADC_SEQ_AVG_EN
    check("nominal_samples", samples, 24'hABC123);
    check("nominal_valid", sample_valid, 2'b11);
`endif
    wait_done(200, e);
    check("scan_period", e, 14);

    // ready held low for 10 cycles on the first command of a scan
    ready_mode = 2; hold_cnt = 10; vcount = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (adc_command_valid) vcount++;
      if (scan_done) break;
    end
    check("hold_valid_cycles", vcount, 12);
    ready_mode = 0;

    // wrong channel on slot 0
    rsp_mode = 2;
    wait_done(200, e);
    check("mismatch_flag", err_mismatch, 1'b1);
`ifndef ADC_SEQ_AVG_EN
    check("mismatch_slot0_kept", samples[11:0], 12'h123);
`endif
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    check("mismatch_cleared", err_mismatch, 1'b0);

    // no response on slot 0, then a late one
    rsp_mode = 3;
    wait_done(200, e);
    check("timeout_flag", err_timeout, 1'b1);
    check("late_rsp_mismatch", err_mismatch, 1'b1);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;

    // randomized traffic
    ready_mode = 1; rsp_mode = 1; data_mode = 1; stray_en = 1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      err_clear = ($urandom_range(0, 49) == 0);
    end
    err_clear = 1'b0; stray_en = 0; ready_mode = 0; rsp_mode = 0; data_mode = 0; enable = 1'b1;
    wait_done(400, e);
    wait_done(400, e);

    // enable dropped during slot 0: scan finishes, then no more commands
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (adc_command_valid && adc_command_channel == 5'(CF)) break;
    end
    enable = 1'b0;
    wait_done(100, e);
    vcount = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (adc_command_valid) vcount++;
    end
    check("stopped_no_commands", vcount, 0);

    // reset while waiting for a response
    enable = 1'b1;
    wait_valid(50, 1'b1);
    wait_valid(50, 1'b0);
    reset_reset = 1'b1; enable = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset");
    reset_reset = 1'b0;
    repeat (5) @(negedge clk);
    reset_reset = 1'b1;
    @(negedge clk);
    reset_reset = 1'b0;

    // ch1 data 100,101,102,103 across consecutive scans
    data_mode = 2; avg_val = 100; enable = 1'b1;
    for (int s = 0; s < 4; s++) begin
      wait_done(200, e);
`ifdef ADC_SEQ_AVG_EN
      if (s < 3) begin
        check("avg_pending_sample", samples[11:0], 12'd0);
        check("avg_pending_valid", sample_valid[0], 1'b0);
      end else begin
        check("avg_result", samples[11:0], 12'd101);
        check("avg_valid", sample_valid[0], 1'b1);
        check("avg_ch2", samples[23:12], 12'h055);
      end
`else
      check("direct_sample", samples[11:0], 12'(100 + s));
`endif
    end
    enable = 1'b0;
    repeat (30) @(negedge clk);
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/adc_scan_sequencer.md
Name: adc_scan_sequencer

Overview:
- Drives the on-chip modular ADC command/response streaming interface.
- Round-robin scans a contiguous block of NUM_CH analog channels and holds the latest 12-bit result per channel in registers for the game logic (joystick/paddle inputs).
- Checks response integrity: a channel mismatch or a response timeout sets a sticky error flag.
- Sits between the ADC core and the VGA game datapath.

Parameters:
- NUM_CH, 2: number of channels scanned, 1..8.
- CH_FIRST, 1: ADC channel number of slot 0. Slot i uses channel CH_FIRST+i.
- SCAN_GAP, 1000: idle clocks between the end of one scan and the start of the next, 0..65535.
- TIMEOUT, 255: maximum clocks waited in WAIT_RSP before abandoning a slot, >=1.

Ports:
- clk_clk  in  1  system clock; single clock domain.
- reset_reset  in  1  synchronous, active-high reset.
- enable  in  1  1 = scan continuously. 0 = stop at the end of the current scan.
- adc_command_valid  out  1  command valid.
- adc_command_channel  out  5  channel to convert.
- adc_command_startofpacket  out  1  tied equal to adc_command_valid.
- adc_command_endofpacket  out  1  tied equal to adc_command_valid.
- adc_command_ready  in  1  ADC accepts the command.
- adc_response_valid  in  1  conversion result valid.
- adc_response_channel  in  5  channel of the result.
- adc_response_data  in  12  conversion result.
- samples  out  12*NUM_CH  slot i occupies bits [12i+11:12i].
- sample_valid  out  NUM_CH  bit i set once slot i has been written; sticky until reset.
- scan_done  out  1  one-cycle pulse when the last slot of a scan completes.
- err_mismatch  out  1  sticky: response channel wrong, or a response arrived with no command outstanding.
- err_timeout  out  1  sticky: no response within TIMEOUT clocks.
- err_clear  in  1  clears both error flags; a new error in the same cycle wins.

Behaviour:
- Reset: all outputs 0, samples 0, slot index 0, FSM in IDLE. Reset mid-operation abandons any outstanding command.
- All outputs are registered.
- IDLE:
  - If enable=1: go to SEND with idx=0.
  - adc_command_valid rises the cycle after enable is first sampled high.
- SEND:
  - Drive valid=sop=eop=1 and channel=CH_FIRST+idx.
  - Hold all of these stable until adc_command_ready=1 is sampled.
  - On that edge: valid drops next cycle, go to WAIT_RSP, clear the timeout counter.
- WAIT_RSP: count clocks.
  - Response with channel==CH_FIRST+idx: write samples[idx]=data and set sample_valid[idx] on the next edge.
  - Response with any other channel: set err_mismatch; samples unchanged.
  - Counter reaches TIMEOUT with no response: set err_timeout.
  - In all three cases go to ADVANCE.
- ADVANCE (1 cycle):
  - If idx<NUM_CH-1: idx+1, go to SEND.
  - Else: scan_done=1 for one cycle, idx=0, go to GAP.
- GAP:
  - Count SCAN_GAP clocks. When done, go to SEND if enable=1, else IDLE.
  - SCAN_GAP=0 means go straight to SEND/IDLE.
- enable falling mid-scan: the current scan completes in full; the stop is decided only at the GAP exit.
- adc_response_valid in IDLE, SEND or GAP: data is ignored and err_mismatch is set.
- Late response after a timeout: treated as a stray response.
- Counters:
  - Timeout counter is 8 bits minimum; sized to hold TIMEOUT.
  - Gap counter is 16 bits; no wrap is reachable.
- Slot index: wraps NUM_CH-1 to 0 only via ADVANCE.

Optional Feature:
- Macro: ADC_SEQ_AVG_EN.
- With the macro defined:
  - Each slot has a 14-bit accumulator and a 2-bit count.
  - Every matched response adds data to the accumulator.
  - On the 4th sample: samples[idx] = acc[13:2], sample_valid[idx] is set, and the accumulator and count clear.
  - samples therefore update once per 4 scans.
  - Reset clears the accumulators and counts.
  - Mismatched or timed-out slots do not advance the count.
- Without the macro: every matched response writes samples directly, as described above; no accumulators exist.

Test Plan:
- NUM_CH=2, CH_FIRST=1, SCAN_GAP=4, ready always 1, responses 3 cycles after command with data 0x123 (ch1) and 0xABC (ch2) -> commands issued for channel 1 then 2; samples=0xABC_123; sample_valid=2'b11; scan_done pulses once per scan, 4 idle clocks apart.
- Ready held low 10 cycles in SEND -> valid, channel, sop and eop stay constant for all 10 cycles; exactly one command is accepted.
- Response carries channel 5 while 1 is expected -> err_mismatch=1; samples[0] unchanged; sequencer proceeds to channel 2. err_clear=1 -> flag returns to 0.
- No response, TIMEOUT=8 -> err_timeout set after 8 clocks in WAIT_RSP; next slot commanded. A response arriving later sets err_mismatch.
- enable dropped during slot 0 of a 2-slot scan -> slot 1 still completes, scan_done pulses, FSM returns to IDLE and no further commands are issued. Reset asserted in WAIT_RSP -> all outputs 0 the next cycle.
- With ADC_SEQ_AVG_EN, ch1 data 100, 101, 102, 103 -> samples[0] stays 0 and sample_valid[0]=0 until the 4th response, then becomes 101 (406>>2).
